// File: rtl/plru_upd_sched.sv
`timescale 1ns/1ps
// plru_upd_sched: sequences hit updates from four lookup lanes and refill
// victim requests onto the one-at-a-time drive/done handshake of the 32-entry
// uTLB PLRU engine, and returns the chosen victim to the refill requester.
// Optional feature macro: PLRU_SCHED_TIMEOUT_EN (WAIT-state watchdog, sched_err).
//
// Handshakes: a lane transfers when lane_req_vld & lane_req_rdy are both high
// at a rising edge; refill_req is a level held until the refill_ack pulse;
// every PLRU transaction starts with one drive pulse and ends with one
// plru_done pulse, which is only honoured in the ISSUE and WAIT states.
module plru_upd_sched #(
   parameter int NUM_LANES = 4
`ifdef PLRU_SCHED_TIMEOUT_EN
  ,parameter int TIMEOUT   = 32
`endif
) (
   input  logic                      forever_cpuclk,
   input  logic                      cpurst,
   input  logic [NUM_LANES-1:0]      lane_req_vld,
   input  logic [32*NUM_LANES-1:0]   lane_req_hit,
   output logic [NUM_LANES-1:0]      lane_req_rdy,
   input  logic                      refill_req,
   input  logic [31:0]               entry_vld,
   output logic                      refill_ack,
   output logic [31:0]               refill_victim,
   output logic [31:0]               plru_hit_vec,
   output logic                      plru_hit_vld,
   output logic                      plru_refill_vld,
   output logic                      plru_refill_on,
   output logic                      plru_drive_hit,
   output logic                      plru_drive_miss,
   input  logic                      plru_done,
   input  logic [31:0]               plru_ref_num,
   output logic                      sched_busy,
   output logic                      sched_err
);

   localparam int LW = $clog2(NUM_LANES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HIT_ISSUE,
      S_HIT_WAIT,
      S_MISS_ISSUE,
      S_MISS_WAIT,
      S_ACK
   } state_e;

   state_e                 state_q;
   logic [NUM_LANES-1:0]   hold_vld_q;
   logic [31:0]            hold_hit_q [NUM_LANES];
   logic [LW-1:0]          rr_ptr_q;
   logic [LW-1:0]          gnt_lane_q;
   logic                   last_refill_q;
   logic                   ack_prev_q;
   logic [31:0]            hit_vec_q;
   logic                   hit_vld_q;
   logic                   refill_vld_q;
   logic                   drive_hit_q;
   logic                   drive_miss_q;
   logic                   ack_q;
   logic [31:0]            victim_q;

   logic [LW-1:0]          rr_sel;
   logic [LW-1:0]          rr_idx;
   logic                   rr_found;
   logic                   byp_hit;
   logic [31:0]            byp_vic;
   logic                   refill_elig;
   logic                   grant_refill;
   logic                   grant_lane;
   logic                   in_wait;
   logic                   to_expire;
   logic                   hit_end;
   logic [NUM_LANES-1:0]   lane_clr;

   assign lane_req_rdy    = ~hold_vld_q;
   assign refill_ack      = ack_q;
   assign refill_victim   = victim_q;
   assign plru_hit_vec    = hit_vec_q;
   assign plru_hit_vld    = hit_vld_q;
   assign plru_refill_vld = refill_vld_q;
   assign plru_refill_on  = refill_vld_q;
   assign plru_drive_hit  = drive_hit_q;
   assign plru_drive_miss = drive_miss_q;
   assign sched_busy      = (state_q != S_IDLE) | (|hold_vld_q);

   // Round-robin search over the registered holding slots, starting at the pointer.
   always_comb begin
      rr_found = 1'b0;
      rr_sel   = rr_ptr_q;
      rr_idx   = rr_ptr_q;
      for (int k = 0; k < NUM_LANES; k++) begin
         rr_idx = rr_ptr_q + LW'(k);
         if (!rr_found && hold_vld_q[rr_idx]) begin
            rr_found = 1'b1;
            rr_sel   = rr_idx;
         end
      end
   end

   // Lowest-index invalid entry, used as victim without consulting the PLRU.
   always_comb begin
      byp_hit = 1'b0;
      byp_vic = '0;
      for (int i = 0; i < 32; i++) begin
         if (!byp_hit && !entry_vld[i]) begin
            byp_vic[i] = 1'b1;
            byp_hit    = 1'b1;
         end
      end
   end

   // Refill wins unless it won last time and a lane is waiting; a refill level
   // still present in the cycle right after its ack is the old request.
   assign refill_elig  = refill_req & ~ack_prev_q;
   assign grant_refill = refill_elig & ~(last_refill_q & rr_found);
   assign grant_lane   = rr_found & ~grant_refill;

   assign in_wait = (state_q == S_HIT_WAIT) || (state_q == S_MISS_WAIT);

`ifdef PLRU_SCHED_TIMEOUT_EN
   localparam logic [5:0] TO_LAST = 6'(TIMEOUT - 1);

   logic [5:0] to_cnt_q;
   logic       err_q;

   assign to_expire = in_wait & ~plru_done & (to_cnt_q == TO_LAST);
   assign sched_err = err_q;

   // Watchdog: counts consecutive WAIT cycles; sticky error on expiry.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         to_cnt_q <= in_wait ? to_cnt_q + 6'd1 : 6'd0;
         if (to_expire) begin
            err_q <= 1'b1;
         end
      end
   end
`else
   assign to_expire = 1'b0;
   assign sched_err = 1'b0;
`endif

   // A hit transaction ends on done (ISSUE or WAIT) or on watchdog abort.
   assign hit_end = ((state_q == S_HIT_ISSUE) && plru_done) ||
                    ((state_q == S_HIT_WAIT) && (plru_done || to_expire));

   always_comb begin
      lane_clr = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         lane_clr[i] = hit_end && (gnt_lane_q == LW'(i));
      end
   end

   // Per-lane 1-deep holding registers: capture when empty, free when served.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         hold_vld_q <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            hold_hit_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_clr[i]) begin
               hold_vld_q[i] <= 1'b0;
            end else if (lane_req_vld[i] && !hold_vld_q[i]) begin
               hold_vld_q[i] <= 1'b1;
               hold_hit_q[i] <= lane_req_hit[32*i +: 32];
            end
         end
      end
   end

   // Scheduler FSM with registered PLRU-side and refill-side outputs.
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q       <= S_IDLE;
         rr_ptr_q      <= '0;
         gnt_lane_q    <= '0;
         last_refill_q <= 1'b0;
         ack_prev_q    <= 1'b0;
         hit_vec_q     <= '0;
         hit_vld_q     <= 1'b0;
         refill_vld_q  <= 1'b0;
         drive_hit_q   <= 1'b0;
         drive_miss_q  <= 1'b0;
         ack_q         <= 1'b0;
         victim_q      <= '0;
      end else begin
         drive_hit_q  <= 1'b0;
         drive_miss_q <= 1'b0;
         ack_q        <= 1'b0;
         ack_prev_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_refill) begin
                  last_refill_q <= 1'b1;
                  if (byp_hit) begin
                     victim_q <= byp_vic;
                     ack_q    <= 1'b1;
                     state_q  <= S_ACK;
                  end else begin
                     refill_vld_q <= 1'b1;
                     drive_miss_q <= 1'b1;
                     state_q      <= S_MISS_ISSUE;
                  end
               end else if (grant_lane) begin
                  last_refill_q <= 1'b0;
                  gnt_lane_q    <= rr_sel;
                  rr_ptr_q      <= rr_sel + LW'(1);
                  hit_vec_q     <= hold_hit_q[rr_sel];
                  hit_vld_q     <= 1'b1;
                  drive_hit_q   <= 1'b1;
                  state_q       <= S_HIT_ISSUE;
               end
            end
            S_HIT_ISSUE, S_HIT_WAIT: begin
               if (hit_end) begin
                  hit_vec_q <= '0;
                  hit_vld_q <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  state_q   <= S_HIT_WAIT;
               end
            end
            S_MISS_ISSUE, S_MISS_WAIT: begin
               if (plru_done) begin
                  victim_q     <= plru_ref_num;
                  refill_vld_q <= 1'b0;
                  ack_q        <= 1'b1;
                  state_q      <= S_ACK;
               end else if (to_expire) begin
                  victim_q     <= 32'h1;
                  refill_vld_q <= 1'b0;
                  ack_q        <= 1'b1;
                  state_q      <= S_ACK;
               end else begin
                  state_q      <= S_MISS_WAIT;
               end
            end
            S_ACK: begin
               ack_prev_q <= 1'b1;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_plru_upd_sched.sv
`timescale 1ns/1ps
// tb_plru_upd_sched: self-checking bench for plru_upd_sched. A PLRU responder
// answers drive pulses after a programmable delay; hit vectors and victims
// are predicted into queues and compared when the DUT produces them.
module tb_plru_upd_sched;

   localparam logic [1:0] EV_REF = 2'd1;
   localparam logic [1:0] EV_HIT = 2'd2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   initial forever #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic [3:0]   lane_req_vld;
   logic [127:0] lane_req_hit;
   logic [3:0]   lane_req_rdy;
   logic         refill_req;
   logic [31:0]  entry_vld;
   logic         refill_ack;
   logic [31:0]  refill_victim;
   logic [31:0]  plru_hit_vec;
   logic         plru_hit_vld;
   logic         plru_refill_vld;
   logic         plru_refill_on;
   logic         plru_drive_hit;
   logic         plru_drive_miss;
   logic         plru_done;
   logic [31:0]  plru_ref_num;
   logic         sched_busy;
   logic         sched_err;

   logic         resp_done;
   logic         poke_done;
   logic         resp_en;
   int           resp_dly;
   logic [31:0]  resp_num;

   assign plru_done = resp_done | poke_done;

   plru_upd_sched dut (
      .forever_cpuclk  (clk),
      .cpurst          (rst),
      .lane_req_vld    (lane_req_vld),
      .lane_req_hit    (lane_req_hit),
      .lane_req_rdy    (lane_req_rdy),
      .refill_req      (refill_req),
      .entry_vld       (entry_vld),
      .refill_ack      (refill_ack),
      .refill_victim   (refill_victim),
      .plru_hit_vec    (plru_hit_vec),
      .plru_hit_vld    (plru_hit_vld),
      .plru_refill_vld (plru_refill_vld),
      .plru_refill_on  (plru_refill_on),
      .plru_drive_hit  (plru_drive_hit),
      .plru_drive_miss (plru_drive_miss),
      .plru_done       (resp_done | poke_done),
      .plru_ref_num    (plru_ref_num),
      .sched_busy      (sched_busy),
      .sched_err       (sched_err)
   );

   // ---------------- PLRU responder ----------------
   initial begin
      resp_done    = 1'b0;
      plru_ref_num = '0;
      forever begin
         @(negedge clk);
         if (resp_en && !rst && (plru_drive_hit || plru_drive_miss)) begin
            repeat (resp_dly) @(negedge clk);
            resp_done    = 1'b1;
            plru_ref_num = resp_num;
            @(negedge clk);
            resp_done    = 1'b0;
            plru_ref_num = '0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [31:0] exp_hit_q[$];
   logic [31:0] exp_vic_q[$];
   logic [1:0]  ev_q[$];
   int cmp_cnt = 0;
   int err_cnt = 0;
   int hit_cnt = 0;
   int miss_cnt = 0;
   int ack_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s: DUT event with empty expected queue", name);
   endtask

   // Advance to the next falling edge and score any DUT output events there.
   task automatic tick();
      logic [31:0] e;
      @(negedge clk);
      if (plru_drive_hit) begin
         hit_cnt++;
         ev_q.push_back(EV_HIT);
         if (exp_hit_q.size() == 0) unexpected("hit_vec");
         else begin
            e = exp_hit_q.pop_front();
            check("hit_vec", plru_hit_vec, e);
         end
      end
      if (plru_drive_miss) miss_cnt++;
      if (refill_ack) begin
         ack_cnt++;
         ev_q.push_back(EV_REF);
         if (exp_vic_q.size() == 0) unexpected("victim");
         else begin
            e = exp_vic_q.pop_front();
            check("victim", refill_victim, e);
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic post(input logic [3:0] mask, input logic [31:0] v0, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] v3);
      lane_req_vld = mask;
      lane_req_hit = {v3, v2, v1, v0};
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (sched_busy && n < 100) begin
         tick();
         n++;
      end
      check(name, sched_busy, 1'b0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   typedef struct {
      logic [31:0] ev;
      logic [31:0] num;
      int          dly;
      logic        byp;
      logic [31:0] vic;
   } refill_vec_t;

   refill_vec_t tbl [7];

   // ---------------- main sequence ----------------
   initial begin
      int h0, m0, a0, lat, lat_exp;
      logic [5:0] seq;

      rst = 1'b1; lane_req_vld = '0; lane_req_hit = '0; refill_req = 1'b0;
      entry_vld = '1; poke_done = 1'b0; resp_en = 1'b1; resp_dly = 0; resp_num = '0;

      tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0400, 0, 1'b0, 32'h0000_0400};
      tbl[1] = '{32'hFFFF_FFF3, 32'h0000_0000, 0, 1'b1, 32'h0000_0004};
      tbl[2] = '{32'hFFFF_FFFF, 32'h8000_0000, 3, 1'b0, 32'h8000_0000};
      tbl[3] = '{32'h0000_0000, 32'h0000_0000, 0, 1'b1, 32'h0000_0001};
      tbl[4] = '{32'h7FFF_FFFF, 32'h0000_0000, 0, 1'b1, 32'h8000_0000};
      tbl[5] = '{32'hFFFE_FFFF, 32'h0000_0000, 0, 1'b1, 32'h0001_0000};
      tbl[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 1, 1'b0, 32'h0000_0001};

      repeat (3) tick();
      check("rst_rdy",    lane_req_rdy, 4'hF);
      check("rst_outs",   {plru_hit_vld, plru_refill_vld, plru_refill_on, plru_drive_hit,
                           plru_drive_miss, refill_ack, sched_busy, sched_err}, 8'h00);
      check("rst_victim", refill_victim, 32'h0);
      check("rst_hitvec", plru_hit_vec, 32'h0);
      rst = 1'b0;
      tick();

      // All four lanes post in one cycle: served 0..3 in order.
      h0 = hit_cnt;
      exp_hit_q.push_back(32'h0000_0001); exp_hit_q.push_back(32'h0000_0010);
      exp_hit_q.push_back(32'h0000_0100); exp_hit_q.push_back(32'h0000_1000);
      post(4'hF, 32'h1, 32'h10, 32'h100, 32'h1000);
      tick();
      lane_req_vld = '0;
      check("four_rdy_c1", lane_req_rdy, 4'h0);
      tick();
      check("four_drive_c2", plru_drive_hit, 1'b1);
      tick();
      check("four_rdy_after_done", lane_req_rdy, 4'b0001);
      wait_idle("four_idle");
      check("four_hit_cnt", hit_cnt - h0, 4);
      check("four_rdy_end", lane_req_rdy, 4'hF);

      // Single-lane latency: accept c0, grant c1, drive c2, rdy back c3.
      exp_hit_q.push_back(32'h8000_0001);
      post(4'b0001, 32'h8000_0001, 0, 0, 0);
      tick();
      lane_req_vld = '0;
      check("lat_rdy_c1", lane_req_rdy, 4'b1110);
      check("lat_nodrive_c1", plru_drive_hit, 1'b0);
      tick();
      check("lat_drive_c2", plru_drive_hit, 1'b1);
      check("lat_hitvld_c2", plru_hit_vld, 1'b1);
      tick();
      check("lat_rdy_c3", lane_req_rdy, 4'hF);
      check("lat_busy_c3", sched_busy, 1'b0);

      // Round-robin: pointer is past lane 0, so lane 2 goes before lane 0.
      exp_hit_q.push_back(32'h000B_0000); exp_hit_q.push_back(32'h0000_000A);
      post(4'b0101, 32'h0000_000A, 0, 32'h000B_0000, 0);
      tick();
      lane_req_vld = '0;
      wait_idle("rr_idle");

      // Refill vectors.
      for (int r = 0; r < 7; r++) begin
         entry_vld = tbl[r].ev;
         resp_num  = tbl[r].num;
         resp_dly  = tbl[r].dly;
         lat_exp   = tbl[r].byp ? 1 : tbl[r].dly + 2;
         exp_vic_q.push_back(tbl[r].vic);
         m0 = miss_cnt; a0 = ack_cnt; lat = 0;
         refill_req = 1'b1;
         while (ack_cnt == a0 && lat < 60) begin
            tick();
            lat++;
         end
         refill_req = 1'b0;
         check($sformatf("refill%0d_latency", r), lat, lat_exp);
         check($sformatf("refill%0d_drive_miss", r), miss_cnt - m0, tbl[r].byp ? 0 : 1);
         tick();
         check($sformatf("refill%0d_ack_pulse", r), refill_ack, 1'b0);
         check($sformatf("refill%0d_victim_held", r), refill_victim, tbl[r].vic);
         tick();
      end

      // Refill held continuously with lane 2 pending: refill, lane 2, refill.
      entry_vld = '1; resp_dly = 1; resp_num = 32'h0000_0020;
      exp_hit_q.push_back(32'h0C00_0000);
      exp_vic_q.push_back(32'h0000_0020); exp_vic_q.push_back(32'h0000_0020);
      ev_q.delete();
      a0 = ack_cnt; lat = 0;
      refill_req = 1'b1;
      post(4'b0100, 0, 0, 32'h0C00_0000, 0);
      tick();
      lane_req_vld = '0;
      while (ack_cnt < a0 + 2 && lat < 100) begin
         tick();
         lat++;
      end
      refill_req = 1'b0;
      seq = 6'h3F;
      if (ev_q.size() == 3) seq = {ev_q[0], ev_q[1], ev_q[2]};
      check("alt_order", seq, {EV_REF, EV_HIT, EV_REF});
      wait_idle("alt_idle");

      // Reset in HIT_WAIT with a second lane pending; a late done is ignored.
      resp_en = 1'b0;
      exp_hit_q.push_back(32'h4000_0000);
      post(4'b1010, 0, 32'h0000_0002, 0, 32'h4000_0000);
      tick();
      lane_req_vld = '0;
      tick();
      tick();
      check("rst_mid_hitvld", plru_hit_vld, 1'b1);
      check("rst_mid_hitvec", plru_hit_vec, 32'h4000_0000);
      rst = 1'b1;
      #1;
      check("rst_mid_rdy", lane_req_rdy, 4'hF);
      check("rst_mid_outs", {plru_hit_vld, plru_refill_vld, plru_refill_on, plru_drive_hit,
                             plru_drive_miss, refill_ack, sched_busy, sched_err}, 8'h00);
      check("rst_mid_hitvec0", plru_hit_vec, 32'h0);
      check("rst_mid_victim", refill_victim, 32'h0);
      tick();
      rst = 1'b0;
      poke_done = 1'b1;
      tick();
      poke_done = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         check("post_rst_quiet", {plru_hit_vld, plru_refill_vld, plru_refill_on, plru_drive_hit,
                                  plru_drive_miss, refill_ack, sched_busy}, 7'h00);
      end
      check("post_rst_rdy", lane_req_rdy, 4'hF);
      resp_en = 1'b1;

`ifdef PLRU_SCHED_TIMEOUT_EN
      // No done after drive_miss: ack after 32 WAIT cycles with victim 1.
      resp_en = 1'b0;
      entry_vld = '1;
      exp_vic_q.push_back(32'h0000_0001);
      a0 = ack_cnt; lat = 0;
      refill_req = 1'b1;
      while (ack_cnt == a0 && lat < 80) begin
         tick();
         lat++;
      end
      refill_req = 1'b0;
      check("timeout_latency", lat, 34);
      check("timeout_err", sched_err, 1'b1);
      repeat (5) tick();
      check("timeout_err_sticky", sched_err, 1'b1);
      pulse_reset();
      check("timeout_err_cleared", sched_err, 1'b0);
      resp_en = 1'b1;
`else
      pulse_reset();
      check("err_tied_low", sched_err, 1'b0);
`endif

      check("hit_queue_drained", exp_hit_q.size(), 0);
      check("vic_queue_drained", exp_vic_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/plru_upd_sched.md
# plru_upd_sched

Scheduler that sequences the 32-entry uTLB PLRU replacement engine. Buffers hit-update requests from four lookup lanes plus one refill (victim) request, arbitrates them, drives the PLRU's drive/done handshake one transaction at a time, and returns the chosen victim to the refill requester. Sits between the uTLB lookup/refill logic and the `plru` block.

## Interface
- `NUM_LANES`, 4: hit-update lanes (fixed at 4 in this revision).
- `TIMEOUT`, 32: cycles allowed in WAIT before abort (only with macro, range 2..63).

Ports:
- `forever_cpuclk`  in  1  clock, all flops rising edge.
- `cpurst`  in  1  reset, asynchronous, active-high.
- `lane_req_vld`  in  4  lane i has a hit update.
- `lane_req_hit`  in  128  lane i one-hot hit vector at [32i+31:32i].
- `lane_req_rdy`  out  4  lane i holding register empty.
- `refill_req`  in  1  level request for a victim; held until `refill_ack`.
- `entry_vld`  in  32  uTLB entry valid bits.
- `refill_ack`  out  1  one-cycle pulse, `refill_victim` valid.
- `refill_victim`  out  32  one-hot victim, held until next ack.
- `plru_hit_vec`  out  32  hit vector to PLRU.
- `plru_hit_vld`  out  1  hit transaction in flight.
- `plru_refill_vld`, `plru_refill_on`  out  1 each  refill transaction in flight.
- `plru_drive_hit`, `plru_drive_miss`  out  1 each  one-cycle start pulses.
- `plru_done`  in  1  one-cycle completion pulse from PLRU.
- `plru_ref_num`  in  32  PLRU victim, valid in `plru_done` cycle.
- `sched_busy`  out  1  FSM not IDLE or any holding register full.
- `sched_err`  out  1  sticky timeout flag.

## Operation
- Per-lane 1-deep holding register; `lane_req_rdy[i]` = holding empty (combinational from flop). Capture on `vld & rdy`.
- FSM states: IDLE, HIT_ISSUE, HIT_WAIT, MISS_ISSUE, MISS_WAIT, ACK.
- IDLE grant: `refill_req` wins unless previous grant was a refill and a lane is pending (alternation, no starvation). Among lanes: round-robin, pointer = last granted lane + 1 mod 4.
- Refill with `~&entry_vld`: bypass PLRU; IDLE -> ACK, victim = lowest-index invalid entry; no drive pulse.
- Otherwise refill: IDLE -> MISS_ISSUE (`plru_drive_miss`=1) -> MISS_WAIT; on done, latch `plru_ref_num` -> ACK.
- Hit: IDLE -> HIT_ISSUE (`plru_drive_hit`=1) -> HIT_WAIT; on done, clear granted lane's holding register -> IDLE.
- `plru_hit_vec`/`plru_hit_vld` or `plru_refill_vld`/`plru_refill_on` stable from ISSUE through done cycle; zero in IDLE.
- `plru_done` sampled in ISSUE and WAIT; ignored in IDLE and ACK.
- ACK: `refill_ack`=1 one cycle -> IDLE. `refill_req` ignored in the cycle after ack.

## Timing
- Reset values: all outputs 0 except `lane_req_rdy`=4'hF; FSM IDLE, holding registers empty, RR pointer 0, `refill_victim`=0.
- Hit latency: accept cycle 0, IDLE grant cycle 1, drive pulse cycle 2, done earliest cycle 2, lane rdy high cycle after done.
- Refill PLRU path: req seen in IDLE at cycle n, drive_miss n+1, ack the cycle after done. Bypass path: ack at n+1.
- Same-cycle lane accept and grant of that lane not possible (grant uses registered holding only).
- Reset mid-transaction: immediate return to IDLE, pending updates dropped; late `plru_done` ignored.

## Configuration
- `PLRU_SCHED_TIMEOUT_EN` defined: 6-bit counter runs in WAIT states; after `TIMEOUT` cycles without done, abort: hit -> drop lane entry, IDLE; miss -> victim 32'h1, ACK. `sched_err` set, cleared only by reset.
- Undefined: WAIT holds indefinitely; `sched_err` tied 0; no counter.

## Test plan
- Reset: assert `cpurst` mid-HIT_WAIT -> all outputs 0, rdy=4'hF; done pulse next cycle produces no activity.
- Lanes 0..3 all post 32'h1<<(4i) same cycle -> four drive_hit pulses, vectors in order 0x1,0x10,0x100,0x1000; rdy[i] rises after its done.
- All entry_vld=1, refill_req, PLRU returns 32'h0000_0400 -> one drive_miss, `refill_ack` one cycle after done, victim 32'h400.
- entry_vld=32'hFFFF_FFF3 with refill_req -> no drive_miss, ack at n+1, victim 32'h4.
- Refill held continuously plus lane 2 pending -> grants alternate refill, lane 2, refill.
- With macro, TIMEOUT=32, no done after drive_miss -> ack after 32 WAIT cycles, victim 32'h1, `sched_err`=1 until reset.
